// File: rtl/mux_scan_pkg.sv
// ============================================================================
// mux_scan_pkg : shared state encoding and default select width
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_scan_pkg;

  localparam int SEL_W_DEFAULT = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctr.sv
// ============================================================================
// mux_scan_ctr : select counter with clear priority and terminal-count flag
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_scan_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/mux_scan_sampler.sv
// ============================================================================
// mux_scan_sampler : steps a mux select and captures one bit per input into a
// frame. Option: MUX_SCAN_CONTINUOUS_EN rescans back-to-back until reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mux_o,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               done,
  output logic [2**SEL_W-1:0] data,
  output logic               valid
);

  localparam int N = 2**SEL_W;

  state_t         state_q, state_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [N-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           ctr_clr, ctr_inc, ctr_tc;
  logic [SEL_W-1:0] ctr_cnt;

  mux_scan_ctr #(.W(SEL_W)) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .inc (ctr_inc),
    .cnt (ctr_cnt),
    .tc  (ctr_tc)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ctr_clr  = 1'b1;
    ctr_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        shadow_d[ctr_cnt] = mux_o;
        ctr_clr = 1'b0;
        ctr_inc = 1'b1;
        // Frame is loaded from the updated shadow so the last bit lands too.
        if (ctr_tc) begin
          data_d  = shadow_d;
          valid_d = 1'b1;
          ctr_clr = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        state_d = ST_SCAN;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign sel   = ctr_cnt;
  assign busy  = (state_q == ST_SCAN);
  assign done  = (state_q == ST_DONE);
  assign data  = data_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sampler.sv
// ============================================================================
// tb_mux_scan_sampler : closed-loop bench, behavioural mux fed from a pattern
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic       mux_o;
  logic [2:0] sel;
  logic       busy, done, valid;
  logic [7:0] data;

  logic       start2 = 1'b0;
  logic [3:0] pattern2 = 4'h0;
  logic       mux2_o;
  logic [1:0] sel2;
  logic       busy2, done2, valid2;
  logic [3:0] data2;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign mux_o  = pattern[sel];
  assign mux2_o = pattern2[sel2];

  mux_scan_sampler #(.SEL_W(3)) u_dut (
    .clk (clk), .rst (rst), .start (start), .mux_o (mux_o),
    .sel (sel), .busy (busy), .done (done), .data (data), .valid (valid)
  );

  mux_scan_sampler #(.SEL_W(2)) u_dut2 (
    .clk (clk), .rst (rst), .start (start2), .mux_o (mux2_o),
    .sel (sel2), .busy (busy2), .done (done2), .data (data2), .valid (valid2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller just after the edge that accepted start.
  task automatic pulse_start(input logic [7:0] exp);
    tick();
    start = 1'b1;
    exp_q.push_back(exp);
    tick();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) check_val("unexpected_done", 32'd1, 32'd0);
      else check_val("frame_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      check_val("frame_valid", {31'd0, valid}, 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int cnt;
    repeat (3) tick();
    check_val("rst_sel",   {29'd0, sel},   32'd0);
    check_val("rst_busy",  {31'd0, busy},  32'd0);
    check_val("rst_done",  {31'd0, done},  32'd0);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_data",  {24'd0, data},  32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check_val("release_idle", {31'd0, busy}, 32'd0);

`ifndef MUX_SCAN_CONTINUOUS_EN
    // Single pulse: sel walks 0..7, done after the eighth scan edge.
    pattern = 8'hA5;
    pulse_start(8'hA5);
    check_val("t1_busy", {31'd0, busy}, 32'd1);
    check_val("t1_sel0", {29'd0, sel}, 32'd0);
    check_val("t1_valid_lo", {31'd0, valid}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_val("t1_sel", {29'd0, sel}, i);
      check_val("t1_no_done", {31'd0, done}, 32'd0);
    end
    tick();
    check_val("t1_done", {31'd0, done}, 32'd1);
    check_val("t1_sel_done", {29'd0, sel}, 32'd0);
    check_val("t1_data", {24'd0, data}, 32'h A5);
    tick();
    check_val("t1_done_1cyc", {31'd0, done}, 32'd1 - 32'd1);
    check_val("t1_valid_hold", {31'd0, valid}, 32'd1);

    // start held 20 cycles: one scan per IDLE entry, none accepted in DONE.
    pattern = 8'h3C;
    d0 = n_done;
    tick();
    start = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    repeat (9) tick();
    check_val("t2_done", {31'd0, done}, 32'd1);
    tick();
    check_val("t2_idle_after_done", {31'd0, busy}, 32'd0);
    repeat (10) tick();
    start = 1'b0;
    check_val("t2_idle_end", {31'd0, busy}, 32'd0);
    repeat (12) tick();
    check_val("t2_scan_count", n_done - d0, 32'd2);
    check_val("t2_data", {24'd0, data}, 32'h3C);

    // Old frame stays visible while a new one is captured.
    pattern = 8'h00;
    pulse_start(8'h00);
    repeat (8) tick();
    check_val("t3_data0", {24'd0, data}, 32'h00);
    tick();
    pattern = 8'hFF;
    pulse_start(8'hFF);
    check_val("t3_valid_lo", {31'd0, valid}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check_val("t3_data_stable", {24'd0, data}, 32'h00);
      check_val("t3_valid_scan", {31'd0, valid}, 32'd0);
    end
    tick();
    check_val("t3_done", {31'd0, done}, 32'd1);
    check_val("t3_data_new", {24'd0, data}, 32'hFF);
    tick();

    // Asynchronous reset mid-scan.
    pattern = 8'h5A;
    pulse_start(8'h5A);
    repeat (4) tick();
    check_val("t4_sel4", {29'd0, sel}, 32'd4);
    rst = 1'b1;
    #1;
    check_val("t4_sel",   {29'd0, sel},   32'd0);
    check_val("t4_busy",  {31'd0, busy},  32'd0);
    check_val("t4_done",  {31'd0, done},  32'd0);
    check_val("t4_valid", {31'd0, valid}, 32'd0);
    check_val("t4_data",  {24'd0, data},  32'd0);
    exp_q.delete();
    d0 = n_done;
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check_val("t4_no_scan", {31'd0, busy}, 32'd0);
    check_val("t4_no_done", n_done - d0, 32'd0);
`else
    // Continuous: frames every 9 cycles, valid never drops.
    pattern = 8'h0F;
    pulse_start(8'h0F);
    cnt = 0;
    while (!done && cnt < 20) begin
      tick();
      cnt++;
    end
    check_val("c_first_done", cnt, 32'd8);
    pattern = 8'hF0;
    exp_q.push_back(8'hF0);
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (!done) check_val("c_valid_high", {31'd0, valid}, 32'd1);
    end while (!done && cnt < 20);
    check_val("c_period", cnt, 32'd9);
    check_val("c_data", {24'd0, data}, 32'hF0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    // Narrow instance: four scan edges per frame.
    pattern2 = 4'b1001;
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cnt = 0;
    while (!done2 && cnt < 10) begin
      tick();
      cnt++;
    end
    check_val("w2_latency", cnt, 32'd4);
    check_val("w2_data", {28'd0, data2}, 32'h9);
    check_val("w2_valid", {31'd0, valid2}, 32'd1);

    repeat (2) tick();
    check_val("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
